// File: rtl/count_enable_gen.sv
// Prescaled count-enable generator with run/stop control for up_down_counter.
// Optional dir_in debounce is enabled by defining DIR_DEBOUNCE_EN.
//
// state | meaning
// IDLE  | prescaler cleared, no pulses, sel tracks direction every cycle
// RUN   | prescaler counting, enable pulses on wrap, sel updates on wrap only
module count_enable_gen #(
  parameter int unsigned       DIV_W       = 24,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV = 24'd12499999,
  parameter logic [15:0]       DB_CYCLES   = 16'd50000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             div_load_i,
  input  logic [DIV_W-1:0] div_val_i,
  input  logic             dir_in_i,
  output logic             enable_o,
  output logic             sel_o,
  output logic             running_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             enable_q, enable_d;
  logic             sel_q, sel_d;
  logic             running_q, running_d;
  logic             dir_eff;
  logic             wrap;

`ifdef DIR_DEBOUNCE_EN
  logic        sync1_q, sync2_q, dir_db_q;
  logic [15:0] db_cnt_q;

  // A new direction is accepted only after it has held for DB_CYCLES cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dir_db_q <= 1'b0;
      db_cnt_q <= 16'd0;
    end else begin
      sync1_q <= dir_in_i;
      sync2_q <= sync1_q;
      if (sync2_q != dir_db_q) begin
        if (db_cnt_q == DB_CYCLES - 16'd1) begin
          dir_db_q <= sync2_q;
          db_cnt_q <= 16'd0;
        end else begin
          db_cnt_q <= db_cnt_q + 16'd1;
        end
      end else begin
        db_cnt_q <= 16'd0;
      end
    end
  end

  assign dir_eff = dir_db_q;
`else
  logic unused_db;
  assign unused_db = ^DB_CYCLES;
  assign dir_eff   = dir_in_i;
`endif

  assign wrap = (pre_q == div_q);

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    enable_d   = 1'b0;
    sel_d      = sel_q;
    case (state_q)
      IDLE: begin
        sel_d = dir_eff;
        if (div_load_i) div_d = div_val_i;
        if (start_i && !stop_i) begin
          state_d = RUN;
          pre_d   = '0;
        end
      end
      RUN: begin
        if (stop_i) begin
          // Any outstanding divider change takes effect as the run ends.
          state_d    = IDLE;
          pre_d      = '0;
          pend_vld_d = 1'b0;
          if (div_load_i)      div_d = div_val_i;
          else if (pend_vld_q) div_d = pend_q;
        end else begin
          if (wrap) begin
            pre_d    = '0;
            enable_d = 1'b1;
            sel_d    = dir_eff;
            if (pend_vld_q) begin
              div_d      = pend_q;
              pend_vld_d = 1'b0;
            end
          end else begin
            pre_d = pre_q + DIV_W'(1);
          end
          if (div_load_i) begin
            pend_d     = div_val_i;
            pend_vld_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      div_q      <= DEFAULT_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      enable_q   <= 1'b0;
      sel_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      enable_q   <= enable_d;
      sel_q      <= sel_d;
      running_q  <= running_d;
    end
  end

  assign enable_o  = enable_q;
  assign sel_o     = sel_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// Self-checking bench for count_enable_gen (default build, no debounce).
// Reference model tracks the absolute cycle of the next pulse instead of a prescaler.
module tb_count_enable_gen;

  localparam int unsigned DIV_W = 24;
  localparam int          DEF_DIV = 9;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             stop_i = 1'b0;
  logic             div_load_i = 1'b0;
  logic [DIV_W-1:0] div_val_i = '0;
  logic             dir_in_i = 1'b0;
  logic             enable_o, sel_o, running_o;

  count_enable_gen #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(24'd9),
    .DB_CYCLES  (16'd4)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .div_load_i(div_load_i),
    .div_val_i (div_val_i),
    .dir_in_i  (dir_in_i),
    .enable_o  (enable_o),
    .sel_o     (sel_o),
    .running_o (running_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: divider, optional pending divider, and absolute cycle of next pulse.
  int cyc = 0;
  int m_div = DEF_DIV;
  int m_pend = -1;
  int next_pulse = 0;
  bit m_run = 0, m_en = 0, m_sel = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_edge();
    int val;
    val = int'(div_val_i);
    cyc++;
    if (rst_i) begin
      m_run = 0; m_en = 0; m_sel = 0; m_div = DEF_DIV; m_pend = -1;
    end else if (!m_run) begin
      m_en = 0;
      m_sel = dir_in_i;
      if (div_load_i) m_div = val;
      if (start_i && !stop_i) begin
        m_run = 1;
        next_pulse = cyc + m_div + 1;
      end
    end else if (stop_i) begin
      m_run = 0; m_en = 0;
      if (div_load_i) m_div = val;
      else if (m_pend >= 0) m_div = m_pend;
      m_pend = -1;
    end else if (cyc == next_pulse) begin
      m_en = 1;
      m_sel = dir_in_i;
      if (m_pend >= 0) begin m_div = m_pend; m_pend = -1; end
      if (div_load_i) m_pend = val;
      next_pulse = cyc + m_div + 1;
    end else begin
      m_en = 0;
      if (div_load_i) m_pend = val;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("enable", enable_o, m_en);
    chk("sel", sel_o, m_sel);
    chk("running", running_o, m_run);
    start_i = 1'b0;
    stop_i = 1'b0;
    div_load_i = 1'b0;
  endtask

  // Steps until enable is observed; returns the step count or -1 on timeout.
  task automatic wait_pulse(input int max, output int n);
    n = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (enable_o === 1'b1) begin n = i + 1; break; end
    end
  endtask

  task automatic load(input int v);
    div_load_i = 1'b1;
    div_val_i = DIV_W'(v);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    int n;

    // Reset state
    rst_i = 1'b1; dir_in_i = 1'b1;
    step();
    chk("rst_enable", enable_o, 1'b0);
    chk("rst_sel", sel_o, 1'b0);
    chk("rst_running", running_o, 1'b0);
    rst_i = 1'b0; dir_in_i = 1'b0;
    step();

    // Default divider loaded at reset: first pulse DEF_DIV+1 edges after start
    start_i = 1'b1;
    step();
    chk("start_running", running_o, 1'b1);
    wait_pulse(40, n);
    chk_int("default_div_first_pulse", n, DEF_DIV + 1);
    stop_i = 1'b1; step();
    chk("stop_running", running_o, 1'b0);

    // div=3: pulse at 4th edge after start, then every 4
    load(3); step();
    start_i = 1'b1; step();
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("div3_pattern", enable_o, (i % 4) == 0);
    end
    stop_i = 1'b1; step();

    // div=0: enable every cycle, drops on stop edge
    load(0); step();
    start_i = 1'b1; step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("div0_every_cycle", enable_o, 1'b1);
    end
    stop_i = 1'b1; step();
    chk("div0_stop_enable", enable_o, 1'b0);

    // Pending load during RUN: current period kept, new one applied at wrap
    load(3); step();
    start_i = 1'b1; step();
    wait_pulse(20, n);
    chk_int("pend_first", n, 4);
    step();               // pre=1 after this edge
    load(5);
    wait_pulse(20, n);
    chk_int("pend_current_period", n, 3);
    wait_pulse(20, n);
    chk_int("pend_new_period", n, 6);
    wait_pulse(20, n);
    chk_int("pend_new_period2", n, 6);
    stop_i = 1'b1; step();

    // start&stop together in IDLE stays idle
    start_i = 1'b1; stop_i = 1'b1; step();
    chk("start_stop_idle", running_o, 1'b0);

    // Reset mid-run restores the default divider
    load(7); step();
    start_i = 1'b1; step();
    step(); step();       // pre=2
    rst_i = 1'b1; step();
    chk("midrun_rst_running", running_o, 1'b0);
    chk("midrun_rst_enable", enable_o, 1'b0);
    chk("midrun_rst_sel", sel_o, 1'b0);
    rst_i = 1'b0;
    start_i = 1'b1; step();
    wait_pulse(40, n);
    chk_int("midrun_rst_default_div", n, DEF_DIV + 1);
    stop_i = 1'b1; step();

    // Direction change mid-period: sel frozen until the wrap edge
    dir_in_i = 1'b0;
    load(7); step();
    start_i = 1'b1; step();
    step(); step();       // pre=2
    dir_in_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("dir_frozen", sel_o, 1'b0);
    end
    step();
    chk("dir_wrap_enable", enable_o, 1'b1);
    chk("dir_wrap_sel", sel_o, 1'b1);
    stop_i = 1'b1; step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_i      = ($urandom_range(0, 299) == 0);
      start_i    = ($urandom_range(0, 15) == 0);
      stop_i     = ($urandom_range(0, 39) == 0);
      div_load_i = ($urandom_range(0, 11) == 0);
      div_val_i  = DIV_W'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) dir_in_i = ~dir_in_i;
      step();
    end
    rst_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
